// File: rtl/seq_ctrl_pkg.sv
// Shared types, widths and helpers for the sequence detect controller.
// Holds the FSM state enum, the latched config bundle and length helpers.
package seq_ctrl_pkg;

  localparam int MAX_LEN   = 8;
  localparam int CNT_W     = 8;
  localparam int TIMEOUT_W = 16;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    FINISH
  } state_e;

  typedef struct packed {
    logic [MAX_LEN-1:0]   pattern;
    logic [LEN_W-1:0]     len;
    logic [CNT_W-1:0]     target;
    logic [TIMEOUT_W-1:0] timeout;
  } cfg_t;

  // Bit i set when i < len; selects the live part of the window.
  function automatic logic [MAX_LEN-1:0] len_mask(
    input logic [LEN_W-1:0] len
  );
    logic [MAX_LEN-1:0] m;
    for (int i = 0; i < MAX_LEN; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] len
  );
    if (len > LEN_W'(MAX_LEN)) begin
      return LEN_W'(MAX_LEN);
    end
    return len;
  endfunction

endpackage

// File: rtl/sequence_detect_controller_if.sv
// Config, control, serial-input and status bundle of the controller.
// slave: the controller; master: the CSR/stream side driving it.
interface sequence_detect_controller_if;
  import seq_ctrl_pkg::*;

  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [MAX_LEN-1:0]   cfg_pattern;
  logic [LEN_W-1:0]     cfg_len;
  logic [CNT_W-1:0]     cfg_target;
  logic [TIMEOUT_W-1:0] cfg_timeout;
  logic                 start;
  logic                 abort;
  logic                 a_valid;
  logic                 a;
  logic                 busy;
  logic                 detected;
  logic [CNT_W-1:0]     match_count;
  logic                 done;
  logic                 timed_out;

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len,
    input  cfg_target, cfg_timeout,
    input  start, abort, a_valid, a,
    output cfg_ready, busy, detected,
    output match_count, done, timed_out
  );

  modport master (
    output cfg_valid, cfg_pattern, cfg_len,
    output cfg_target, cfg_timeout,
    output start, abort, a_valid, a,
    input  cfg_ready, busy, detected,
    input  match_count, done, timed_out
  );

endinterface

// File: rtl/seq_match_window.sv
// Serial shift window with fill counter and length-masked compare.
// Ports: clear_i/shift_i/bit_i drive the window; hit_o is combinational.
module seq_match_window
  import seq_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic               bit_i,
  input  logic [LEN_W-1:0]   len_i,
  input  logic [MAX_LEN-1:0] pattern_i,
  output logic               hit_o
);

  logic [MAX_LEN-1:0] win_q, win_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_LEN-1:0] mask;
  logic               eq;

  always_comb begin
    win_d  = win_q;
    fill_d = fill_q;
    if (clear_i) begin
      win_d  = '0;
      fill_d = '0;
    end else if (shift_i) begin
      win_d = {win_q[MAX_LEN-2:0], bit_i};
      if (fill_q < len_i) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  assign mask = len_mask(len_i);
  assign eq   = ((win_d ^ pattern_i) & mask) == '0;

  // Hit looks at the post-shift window so the
  // matching bit counts in the cycle it arrives.
  assign hit_o = shift_i && !clear_i &&
                 (fill_d == len_i) && eq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/sequence_detect_controller.sv
// Programmable serial pattern detection controller: config, FSM, counters.
// Ports: clk, rst_n (sync, active-low), bus (slave: cfg/ctl/stream/status).
module sequence_detect_controller
  import seq_ctrl_pkg::*;
(
  input logic                          clk,
  input logic                          rst_n,
  sequence_detect_controller_if.slave  bus
);

  state_e               state_q, state_d;
  cfg_t                 cfg_q, cfg_d, cfg_new;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 det_q, det_d;
  logic                 tout_q, tout_d;
  logic                 cfg_rdy;
  logic                 cfg_acc;
  logic                 go;
  logic                 armed;
  logic                 win_clear;
  logic                 win_shift;
  logic                 hit;

  assign armed   = state_q == ARMED;
  assign cfg_rdy = !armed;
  assign cfg_acc = bus.cfg_valid && cfg_rdy;

  assign cfg_new = '{
    pattern: bus.cfg_pattern,
    len:     clamp_len(bus.cfg_len),
    target:  bus.cfg_target,
    timeout: bus.cfg_timeout
  };

  // A config arriving with start is the one used.
  assign cfg_d = cfg_acc ? cfg_new : cfg_q;
  assign go    = bus.start && cfg_rdy &&
                 (cfg_d.len != '0);

  assign win_shift = armed && bus.a_valid &&
                     !bus.abort;

  seq_match_window u_win (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (win_clear),
    .shift_i   (win_shift),
    .bit_i     (bus.a),
    .len_i     (cfg_q.len),
    .pattern_i (cfg_q.pattern),
    .hit_o     (hit)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_d   = timer_q;
    det_d     = 1'b0;
    tout_d    = tout_q;
    win_clear = 1'b0;
    if (bus.abort) begin
      state_d   = IDLE;
      timer_d   = '0;
      tout_d    = 1'b0;
      win_clear = 1'b1;
    end else if (go) begin
      state_d   = ARMED;
      count_d   = '0;
      timer_d   = '0;
      tout_d    = 1'b0;
      win_clear = 1'b1;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (hit) begin
            det_d   = 1'b1;
            timer_d = '0;
            if (count_q != '1) begin
              count_d = count_q + CNT_W'(1);
            end
            if (cfg_q.target != '0 &&
                count_d == cfg_q.target) begin
              state_d = FINISH;
            end
          end else if (cfg_q.timeout != '0 &&
                       timer_q == cfg_q.timeout
                                  - TIMEOUT_W'(1)) begin
            state_d = FINISH;
            tout_d  = 1'b1;
          end else begin
            timer_d = timer_q + TIMEOUT_W'(1);
          end
        end
        IDLE, FINISH: begin
          state_d = state_q;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      count_q <= '0;
      timer_q <= '0;
      det_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      count_q <= count_d;
      timer_q <= timer_d;
      det_q   <= det_d;
      tout_q  <= tout_d;
    end
  end

  assign bus.cfg_ready   = cfg_rdy;
  assign bus.busy        = armed;
  assign bus.detected    = det_q;
  assign bus.match_count = count_q;
  assign bus.done        = state_q == FINISH;
  assign bus.timed_out   = tout_q;

endmodule

// File: tb/tb_sequence_detect_controller.sv
// Directed bench for sequence_detect_controller.
// Each task drives one scenario and checks its own expected values.
module tb_sequence_detect_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [23:0] stream = 24'b0011_0101_1001_1001_1010_1000;

  sequence_detect_controller_if bus();

  sequence_detect_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [7:0] p, input logic [3:0] l,
                        input logic [7:0] t, input logic [15:0] to);
    bus.cfg_valid = 1'b1;
    bus.cfg_pattern = p;
    bus.cfg_len = l;
    bus.cfg_target = t;
    bus.cfg_timeout = to;
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_abort;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.detected !== 1'b0) begin n_bad++; $display("FAIL reset_det got %b want 0", bus.detected); end
    n_cmp++; if (bus.match_count !== 8'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", bus.match_count); end
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b want 1", bus.cfg_ready); end
    n_cmp++; if (bus.timed_out !== 1'b0) begin n_bad++; $display("FAIL reset_tout got %b want 0", bus.timed_out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pat6;
    logic e;
    do_cfg(8'b0011_0011, 4'd6, 8'd0, 16'd0);
    do_start();
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL p6_busy got %b want 1", bus.busy); end
    n_cmp++; if (bus.cfg_ready !== 1'b0) begin n_bad++; $display("FAIL p6_rdy got %b want 0", bus.cfg_ready); end
    for (int i = 0; i < 24; i++) begin
      bus.a_valid = 1'b1;
      bus.a = stream[23-i];
      tick();
      e = (i == 12) || (i == 16);
      n_cmp++; if (bus.detected !== e) begin n_bad++; $display("FAIL p6_det bit %0d got %b want %b", i, bus.detected, e); end
    end
    bus.a_valid = 1'b0;
    n_cmp++; if (bus.match_count !== 8'd2) begin n_bad++; $display("FAIL p6_cnt got %0d want 2", bus.match_count); end
    do_abort();
  endtask

  task automatic test_overlap;
    logic e;
    do_cfg(8'b0000_1010, 4'd4, 8'd0, 16'd0);
    do_start();
    for (int i = 0; i < 24; i++) begin
      bus.a_valid = 1'b1;
      bus.a = stream[23-i];
      tick();
      e = (i == 6) || (i == 19) || (i == 21);
      n_cmp++; if (bus.detected !== e) begin n_bad++; $display("FAIL ov_det bit %0d got %b want %b", i, bus.detected, e); end
    end
    bus.a_valid = 1'b0;
    n_cmp++; if (bus.match_count !== 8'd3) begin n_bad++; $display("FAIL ov_cnt got %0d want 3", bus.match_count); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL ov_done got %b want 0", bus.done); end
    do_abort();
  endtask

  task automatic test_target;
    logic e;
    do_cfg(8'b0000_1010, 4'd4, 8'd2, 16'd0);
    do_start();
    for (int i = 0; i < 24; i++) begin
      bus.a_valid = 1'b1;
      bus.a = stream[23-i];
      tick();
      e = (i == 6) || (i == 19);
      n_cmp++; if (bus.detected !== e) begin n_bad++; $display("FAIL tg_det bit %0d got %b want %b", i, bus.detected, e); end
      if (i == 19) begin
        n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL tg_done got %b want 1", bus.done); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL tg_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.timed_out !== 1'b0) begin n_bad++; $display("FAIL tg_tout got %b want 0", bus.timed_out); end
      end
    end
    bus.a_valid = 1'b0;
    n_cmp++; if (bus.match_count !== 8'd2) begin n_bad++; $display("FAIL tg_cnt got %0d want 2", bus.match_count); end
    n_cmp++; if (bus.done !== 1'b1) begin n_bad++; $display("FAIL tg_hold got %b want 1", bus.done); end
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL tg_rdy got %b want 1", bus.cfg_ready); end
  endtask

  task automatic test_timeout;
    logic e;
    logic [4:0] bits = 5'b00001;
    do_cfg(8'b0000_0001, 4'd4, 8'd0, 16'd5);
    do_start();
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL to_clr got %b want 0", bus.done); end
    for (int k = 1; k <= 5; k++) begin
      bus.a_valid = 1'b1;
      bus.a = 1'b0;
      tick();
      e = (k == 5);
      n_cmp++; if (bus.done !== e) begin n_bad++; $display("FAIL to_done cyc %0d got %b want %b", k, bus.done, e); end
      n_cmp++; if (bus.timed_out !== e) begin n_bad++; $display("FAIL to_flag cyc %0d got %b want %b", k, bus.timed_out, e); end
    end
    do_start();
    n_cmp++; if (bus.timed_out !== 1'b0) begin n_bad++; $display("FAIL to_restart got %b want 0", bus.timed_out); end
    for (int k = 0; k < 5; k++) begin
      bus.a = bits[4-k];
      tick();
    end
    n_cmp++; if (bus.detected !== 1'b1) begin n_bad++; $display("FAIL tm_det got %b want 1", bus.detected); end
    n_cmp++; if (bus.match_count !== 8'd1) begin n_bad++; $display("FAIL tm_cnt got %0d want 1", bus.match_count); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL tm_done got %b want 0", bus.done); end
    for (int k = 1; k <= 5; k++) begin
      bus.a = 1'b0;
      tick();
      e = (k == 5);
      n_cmp++; if (bus.timed_out !== e) begin n_bad++; $display("FAIL tm_tout cyc %0d got %b want %b", k, bus.timed_out, e); end
    end
    bus.a_valid = 1'b0;
  endtask

  task automatic test_abort;
    do_cfg(8'b0000_1010, 4'd4, 8'd0, 16'd0);
    do_start();
    for (int i = 0; i < 7; i++) begin
      bus.a_valid = 1'b1;
      bus.a = stream[23-i];
      tick();
    end
    bus.a_valid = 1'b0;
    n_cmp++; if (bus.match_count !== 8'd1) begin n_bad++; $display("FAIL ab_pre got %0d want 1", bus.match_count); end
    bus.start = 1'b1;
    do_abort();
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ab_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL ab_done got %b want 0", bus.done); end
    n_cmp++; if (bus.match_count !== 8'd1) begin n_bad++; $display("FAIL ab_cnt got %0d want 1", bus.match_count); end
    n_cmp++; if (bus.cfg_ready !== 1'b1) begin n_bad++; $display("FAIL ab_rdy got %b want 1", bus.cfg_ready); end
    do_start();
    n_cmp++; if (bus.match_count !== 8'd0) begin n_bad++; $display("FAIL ab_rst got %0d want 0", bus.match_count); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL ab_rearm got %b want 1", bus.busy); end
    do_abort();
  endtask

  task automatic test_len_edges;
    logic e;
    logic [7:0] p = 8'b1011_0011;
    do_cfg(8'b0000_1010, 4'd0, 8'd0, 16'd0);
    do_start();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL len0 got %b want 0", bus.busy); end
    bus.cfg_valid = 1'b1;
    bus.cfg_len = 4'd4;
    bus.start = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL cfg_start got %b want 1", bus.busy); end
    do_abort();
    do_cfg(p, 4'd9, 8'd0, 16'd0);
    do_start();
    for (int i = 0; i < 8; i++) begin
      bus.a_valid = 1'b1;
      bus.a = p[7-i];
      tick();
      e = (i == 7);
      n_cmp++; if (bus.detected !== e) begin n_bad++; $display("FAIL len9 bit %0d got %b want %b", i, bus.detected, e); end
    end
    bus.a_valid = 1'b0;
    do_abort();
  endtask

  task automatic test_gaps;
    logic e;
    logic [8:0] v = 9'b1_0101_0010;
    logic [8:0] d = 9'b1_1011_1000;
    do_cfg(8'b0000_1010, 4'd4, 8'd0, 16'd0);
    do_start();
    for (int i = 0; i < 9; i++) begin
      bus.a_valid = v[8-i];
      bus.a = d[8-i];
      tick();
      e = (i == 7);
      n_cmp++; if (bus.detected !== e) begin n_bad++; $display("FAIL gap_det idx %0d got %b want %b", i, bus.detected, e); end
    end
    bus.a_valid = 1'b0;
    n_cmp++; if (bus.match_count !== 8'd1) begin n_bad++; $display("FAIL gap_cnt got %0d want 1", bus.match_count); end
  endtask

  task automatic test_reset_midrun;
    logic [2:0] b = 3'b101;
    do_abort();
    do_start();
    for (int i = 0; i < 3; i++) begin
      bus.a_valid = 1'b1;
      bus.a = b[2-i];
      tick();
    end
    bus.a = 1'b0;
    rst_n = 1'b0;
    tick();
    bus.a_valid = 1'b0;
    n_cmp++; if (bus.detected !== 1'b0) begin n_bad++; $display("FAIL mr_det got %b want 0", bus.detected); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mr_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.match_count !== 8'd0) begin n_bad++; $display("FAIL mr_cnt got %0d want 0", bus.match_count); end
    rst_n = 1'b1;
    tick();
    do_start();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mr_len0 got %b want 0", bus.busy); end
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_pattern = '0;
    bus.cfg_len = '0;
    bus.cfg_target = '0;
    bus.cfg_timeout = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.a_valid = 1'b0;
    bus.a = 1'b0;
    test_reset();
    test_pat6();
    test_overlap();
    test_target();
    test_timeout();
    test_abort();
    test_len_edges();
    test_gaps();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
